// File: rtl/burst_period_ctrl_if.sv
// Control and status bundle for burst_period_ctrl.
// The master modport drives the requests; the slave modport (the controller) returns the status and burst outputs.
interface burst_period_ctrl_if #(
   parameter int CNT_W = 8,
   parameter int N_W   = 3,
   parameter int SH_W  = 2
);
   logic             adjust;
   logic             done;
   logic             abort;
   logic [N_W-1:0]   n;
   logic [SH_W-1:0]  shamt;
   logic             busy;
   logic             tick;
   logic             valid;
   logic             ovf;
   logic [CNT_W-1:0] period;
   logic [N_W-1:0]   burst_idx;

   modport master (
      output adjust, done, abort, n, shamt,
      input  busy, tick, valid, ovf, period, burst_idx
   );

   modport slave (
      input  adjust, done, abort, n, shamt,
      output busy, tick, valid, ovf, period, burst_idx
   );
endinterface

// File: rtl/burst_period_ctrl.sv
// Measures the adjust-release to done interval and scales it by shamt.
// It then replays n+1 ticks at that period; the first tick is 2+period cycles after done and valid marks the last.
module burst_period_ctrl #(
   parameter int CNT_W = 8,
   parameter int N_W   = 3,
   parameter int SH_W  = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   burst_period_ctrl_if.slave io_ctrl
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADJ   = 3'd1,
      S_MEAS  = 3'd2,
      S_SHIFT = 3'd3,
      S_LOAD  = 3'd4,
      S_RUN   = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_meas;
   logic [CNT_W-1:0] r_dcnt;
   logic [CNT_W-1:0] r_period;
   logic [N_W-1:0]   r_burst_idx;
   logic             r_ovf;
   logic [CNT_W-1:0] w_meas_nxt;
   logic [CNT_W-1:0] w_dcnt_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic [N_W-1:0]   w_burst_idx_nxt;
   logic             w_ovf_nxt;
   logic             w_tick;
   logic             w_valid;
   logic [CNT_W-1:0] w_scaled;

   assign w_scaled = r_meas >> io_ctrl.shamt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_meas_nxt      = r_meas;
      w_dcnt_nxt      = r_dcnt;
      w_period_nxt    = r_period;
      w_burst_idx_nxt = r_burst_idx;
      w_ovf_nxt       = r_ovf;
      w_tick          = 1'b0;
      w_valid         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (io_ctrl.adjust) begin
               w_state_nxt = S_ADJ;
            end
         end
         S_ADJ: begin
            if (!io_ctrl.adjust) begin
               w_state_nxt = S_MEAS;
               w_meas_nxt  = '0;
               w_ovf_nxt   = 1'b0;
            end
         end
         S_MEAS: begin
            if (io_ctrl.done) begin
               w_state_nxt = S_SHIFT;
            end else if (&r_meas) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_meas_nxt = r_meas + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            // A zero period would never tick, so the shortest period is one cycle
            w_period_nxt    = (w_scaled == '0) ? CNT_W'(1) : w_scaled;
            w_burst_idx_nxt = '0;
            w_state_nxt     = S_LOAD;
         end
         S_LOAD: begin
            w_dcnt_nxt  = r_period - CNT_W'(1);
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (r_dcnt != '0) begin
               w_dcnt_nxt = r_dcnt - CNT_W'(1);
            end else begin
               w_tick = 1'b1;
               if (r_burst_idx == io_ctrl.n) begin
                  w_valid     = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_dcnt_nxt      = r_period - CNT_W'(1);
                  w_burst_idx_nxt = r_burst_idx + N_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Abort freezes the datapath and suppresses any tick decoded this cycle
      if (io_ctrl.abort && (r_state != S_IDLE)) begin
         w_state_nxt     = S_IDLE;
         w_meas_nxt      = r_meas;
         w_dcnt_nxt      = r_dcnt;
         w_period_nxt    = r_period;
         w_burst_idx_nxt = r_burst_idx;
         w_ovf_nxt       = r_ovf;
         w_tick          = 1'b0;
         w_valid         = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meas      <= '0;
         r_dcnt      <= '0;
         r_period    <= '0;
         r_burst_idx <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_meas      <= w_meas_nxt;
         r_dcnt      <= w_dcnt_nxt;
         r_period    <= w_period_nxt;
         r_burst_idx <= w_burst_idx_nxt;
         r_ovf       <= w_ovf_nxt;
      end
   end

   assign io_ctrl.busy      = (r_state != S_IDLE);
   assign io_ctrl.tick      = w_tick;
   assign io_ctrl.valid     = w_valid;
   assign io_ctrl.ovf       = r_ovf;
   assign io_ctrl.period    = r_period;
   assign io_ctrl.burst_idx = r_burst_idx;

endmodule

// File: tb/tb_burst_period_ctrl.sv
// Directed bench driving an 8-bit and a 4-bit counter instance in lockstep.
// Expected ticks are queued when done is driven and are retired as each instance ticks.
module tb_burst_period_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_period_ctrl_if #(.CNT_W(8), .N_W(3), .SH_W(2)) b8 ();
   burst_period_ctrl_if #(.CNT_W(4), .N_W(3), .SH_W(2)) b4 ();

   assign b4.adjust = b8.adjust;
   assign b4.done   = b8.done;
   assign b4.abort  = b8.abort;
   assign b4.n      = b8.n;
   assign b4.shamt  = b8.shamt;

   burst_period_ctrl #(.CNT_W(8), .N_W(3), .SH_W(2)) u_dut8 (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_ctrl (b8.slave)
   );

   burst_period_ctrl #(.CNT_W(4), .N_W(3), .SH_W(2)) u_dut4 (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_ctrl (b4.slave)
   );

   typedef struct {
      int c;
      int idx;
      int vld;
      int per;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t e8;
   exp_t e4;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   fall8       = -1;
   int   fall4       = -1;
   logic pb8         = 1'b0;
   logic pb4         = 1'b0;
   int   exp_end8, exp_end4, exp_per8, exp_per4, exp_ovf8, exp_ovf4, exp_n;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_period(input int m, input int w, input int sh);
      int sat = (1 << w) - 1;
      int p   = ((m > sat) ? sat : m) >> sh;
      return (p == 0) ? 1 : p;
   endfunction

   // Tick monitors: every tick must match the head of its queue
   always @(negedge clk) begin
      if (b8.tick || b8.valid) begin
         if (q8.size() == 0) begin
            chk("d8_unexpected_tick", 32'({b8.tick, b8.valid}), 0);
         end else begin
            e8 = q8.pop_front();
            chk("d8_tick_cycle", cyc, e8.c);
            chk("d8_tick", 32'(b8.tick), 1);
            chk("d8_tick_idx", 32'(b8.burst_idx), e8.idx);
            chk("d8_valid", 32'(b8.valid), e8.vld);
            chk("d8_period", 32'(b8.period), e8.per);
         end
      end else if (q8.size() != 0 && q8[0].c < cyc) begin
         chk("d8_missed_tick", cyc, q8[0].c);
         void'(q8.pop_front());
      end
      if (b4.tick || b4.valid) begin
         if (q4.size() == 0) begin
            chk("d4_unexpected_tick", 32'({b4.tick, b4.valid}), 0);
         end else begin
            e4 = q4.pop_front();
            chk("d4_tick_cycle", cyc, e4.c);
            chk("d4_tick", 32'(b4.tick), 1);
            chk("d4_tick_idx", 32'(b4.burst_idx), e4.idx);
            chk("d4_valid", 32'(b4.valid), e4.vld);
            chk("d4_period", 32'(b4.period), e4.per);
         end
      end else if (q4.size() != 0 && q4[0].c < cyc) begin
         chk("d4_missed_tick", cyc, q4[0].c);
         void'(q4.pop_front());
      end
      if (pb8 && !b8.busy) fall8 = cyc;
      if (pb4 && !b4.busy) fall4 = cyc;
      pb8 = b8.busy;
      pb4 = b4.busy;
   end

   task automatic prune(input int c);
      while (q8.size() != 0 && q8[q8.size()-1].c >= c) void'(q8.pop_back());
      while (q4.size() != 0 && q4[q4.size()-1].c >= c) void'(q4.pop_back());
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_d8_busy"}, 32'(b8.busy), 0);
      chk({tag, "_d8_tick"}, 32'(b8.tick), 0);
      chk({tag, "_d8_valid"}, 32'(b8.valid), 0);
      chk({tag, "_d8_ovf"}, 32'(b8.ovf), 0);
      chk({tag, "_d8_period"}, 32'(b8.period), 0);
      chk({tag, "_d8_idx"}, 32'(b8.burst_idx), 0);
      chk({tag, "_d4_busy"}, 32'(b4.busy), 0);
      chk({tag, "_d4_tick"}, 32'(b4.tick), 0);
      chk({tag, "_d4_valid"}, 32'(b4.valid), 0);
      chk({tag, "_d4_ovf"}, 32'(b4.ovf), 0);
      chk({tag, "_d4_period"}, 32'(b4.period), 0);
      chk({tag, "_d4_idx"}, 32'(b4.burst_idx), 0);
   endtask

   // Adjust hold, release, mcyc MEAS cycles, then done; queues the expected burst
   task automatic start_op(input int adj, input int mcyc, input int sh, input int nn, input string tag);
      int   d;
      exp_t e;
      b8.n     = 3'(nn);
      b8.shamt = 2'(sh);
      fall8    = -1;
      fall4    = -1;
      for (int i = 0; i < adj; i++) begin
         b8.adjust = 1'b1;
         step();
         if (i == 0) begin
            chk({tag, "_d8_busy_rise"}, 32'(b8.busy), 1);
            chk({tag, "_d4_busy_rise"}, 32'(b4.busy), 1);
         end
      end
      b8.adjust = 1'b0;
      step();
      chk({tag, "_d8_ovf_clear"}, 32'(b8.ovf), 0);
      chk({tag, "_d4_ovf_clear"}, 32'(b4.ovf), 0);
      for (int i = 0; i < mcyc; i++) step();
      b8.done  = 1'b1;
      d        = cyc;
      exp_per8 = exp_period(mcyc, 8, sh);
      exp_per4 = exp_period(mcyc, 4, sh);
      exp_ovf8 = (mcyc >= 256) ? 1 : 0;
      exp_ovf4 = (mcyc >= 16) ? 1 : 0;
      exp_n    = nn;
      exp_end8 = d + 2 + exp_per8 * (nn + 1) + 1;
      exp_end4 = d + 2 + exp_per4 * (nn + 1) + 1;
      for (int i = 0; i <= nn; i++) begin
         e.idx = i;
         e.vld = (i == nn) ? 1 : 0;
         e.c   = d + 2 + exp_per8 * (i + 1);
         e.per = exp_per8;
         q8.push_back(e);
         e.c   = d + 2 + exp_per4 * (i + 1);
         e.per = exp_per4;
         q4.push_back(e);
      end
      step();
      b8.done = 1'b0;
   endtask

   task automatic finish_op(input string tag);
      int g = 0;
      while ((b8.busy || b4.busy) && g < 3000) begin
         step();
         g++;
      end
      chk({tag, "_idle_in_time"}, 32'(g < 3000), 1);
      step();
      step();
      chk({tag, "_d8_busy_fall"}, fall8, exp_end8);
      chk({tag, "_d4_busy_fall"}, fall4, exp_end4);
      chk({tag, "_d8_q_empty"}, q8.size(), 0);
      chk({tag, "_d4_q_empty"}, q4.size(), 0);
      chk({tag, "_d8_period"}, 32'(b8.period), exp_per8);
      chk({tag, "_d4_period"}, 32'(b4.period), exp_per4);
      chk({tag, "_d8_ovf"}, 32'(b8.ovf), exp_ovf8);
      chk({tag, "_d4_ovf"}, 32'(b4.ovf), exp_ovf4);
      chk({tag, "_d8_idx"}, 32'(b8.burst_idx), exp_n);
      chk({tag, "_d4_idx"}, 32'(b4.burst_idx), exp_n);
   endtask

   task automatic wait_first_tick(input string tag);
      int g = 0;
      while (!b8.tick && g < 200) begin
         step();
         g++;
      end
      chk({tag, "_tick_seen"}, 32'(b8.tick), 1);
   endtask

   int abort_c;

   initial begin
      b8.adjust = 1'b0;
      b8.done   = 1'b0;
      b8.abort  = 1'b0;
      b8.n      = '0;
      b8.shamt  = '0;
      rst       = 1'b1;
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;
      step();

      // Nominal: meas 12, shamt 2 -> period 3, three ticks
      start_op(3, 12, 2, 2, "nominal");
      finish_op("nominal");

      // Scaled count of zero is forced to a one-cycle period
      start_op(2, 2, 3, 3, "minper");
      finish_op("minper");

      // 20 MEAS cycles saturate the 4-bit counter but not the 8-bit one
      start_op(3, 20, 0, 0, "ovf");
      finish_op("ovf");

      // Immediate done; also shows ovf cleared on ADJ->MEAS
      start_op(1, 0, 0, 0, "immdone");
      finish_op("immdone");

      // Abort one cycle after the first tick of a five-tick burst
      start_op(3, 12, 2, 4, "abort");
      wait_first_tick("abort");
      step();
      b8.abort = 1'b1;
      abort_c  = cyc;
      prune(abort_c);
      step();
      b8.abort = 1'b0;
      chk("abort_d8_busy", 32'(b8.busy), 0);
      chk("abort_d4_busy", 32'(b4.busy), 0);
      chk("abort_d8_period", 32'(b8.period), 3);
      chk("abort_d4_period", 32'(b4.period), 3);
      chk("abort_d8_idx", 32'(b8.burst_idx), 1);
      repeat (12) step();
      chk("abort_d8_fall", fall8, abort_c + 1);
      chk("abort_d4_fall", fall4, abort_c + 1);

      // Abort landing on a tick cycle must suppress that tick
      start_op(2, 2, 3, 3, "abort_gate");
      wait_first_tick("abort_gate");
      step();
      b8.abort = 1'b1;
      abort_c  = cyc;
      prune(abort_c);
      step();
      b8.abort = 1'b0;
      chk("abort_gate_d8_busy", 32'(b8.busy), 0);
      chk("abort_gate_d8_period", 32'(b8.period), 1);
      chk("abort_gate_d8_idx", 32'(b8.burst_idx), 1);
      repeat (6) step();
      chk("abort_gate_d8_q_empty", q8.size(), 0);

      // Reset held two cycles in RUN, then a clean restart
      start_op(3, 12, 2, 2, "rstrun");
      wait_first_tick("rstrun");
      step();
      rst = 1'b1;
      prune(cyc);
      step();
      step();
      rst = 1'b0;
      chk_zero("rstrun");
      repeat (2) step();
      start_op(1, 5, 0, 1, "restart");
      finish_op("restart");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/burst_period_ctrl.md
# burst_period_ctrl

Parametrised second-generation CA5 controller with its own datapath. It handles the adjust hold, then measures the interval between adjust release and a `done` strobe, and scales that interval by a run-time shift. It then generates a burst of `n+1` evenly spaced `tick` pulses at the scaled period and pulses `valid` on the last one. It replaces the fixed 3-bit controller and its external up/down counters, and adds a programmable shift, abort, overflow detection and a busy indication.

## Interface
- `CNT_W`, 8: width of measurement counter, period register and down counter.
- `N_W`, 3: width of burst-count input `n` and `burst_idx`.
- `SH_W`, 2: width of shift-amount input `shamt`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adjust`  in  1  hold request; measurement starts on its release.
- `done`  in  1  measurement stop strobe; sampled only in MEAS.
- `abort`  in  1  cancel current operation; ignored in IDLE.
- `n`  in  N_W  burst length minus one; sampled every RUN cycle.
- `shamt`  in  SH_W  right-shift applied to the measured count; sampled in SHIFT.
- `busy`  out  1  state != IDLE.
- `tick`  out  1  one-cycle pulse at each period boundary.
- `valid`  out  1  one-cycle pulse coincident with the final tick.
- `ovf`  out  1  sticky: measurement counter saturated.
- `period`  out  CNT_W  current scaled period.
- `burst_idx`  out  N_W  index of the tick in progress.

## Operation
- States: IDLE(0), ADJ(1), MEAS(2), SHIFT(3), LOAD(4), RUN(5). Encodings 6 and 7 return to IDLE next cycle.
- Priority at each edge: `rst` > `abort` (non-IDLE states) > normal transitions.
- IDLE: if `adjust`=1, go to ADJ; otherwise stay.
- ADJ: stay while `adjust`=1. On `adjust`=0, go to MEAS and clear `meas` to 0 and `ovf` to 0.
- MEAS, `done`=0: `meas` increments each cycle.
  - If `meas` is all-ones, it holds and `ovf` is set instead.
- MEAS, `done`=1: go to SHIFT with no increment that cycle. `meas` therefore equals the number of MEAS cycles that preceded `done`.
- SHIFT: `period` <= `meas` >> `shamt` (logical shift). If the result is 0, `period` <= 1. `burst_idx` <= 0. Go to LOAD.
- LOAD: `dcnt` <= `period`-1. Go to RUN.
- RUN, `dcnt`≠0: `dcnt` decrements.
- RUN, `dcnt`=0: `tick`=1 this cycle.
  - If `burst_idx`==`n`: `valid`=1 this cycle, next state IDLE.
  - Otherwise: `dcnt` <= `period`-1, `burst_idx` increments, stay in RUN.
- Abort: next state IDLE. `tick` and `valid` are not asserted in the abort cycle or after it. `period`, `ovf` and `burst_idx` hold their values.
- Inputs outside their sampling states have no effect: `done` outside MEAS, `adjust` outside IDLE/ADJ, `shamt` outside SHIFT.
- `tick` and `valid` are decoded from registered state, `dcnt`, `burst_idx` and `n`. `abort` gates both off.

## Timing
- Reset values: state IDLE; `meas`, `dcnt`, `period`, `burst_idx` = 0; `busy`, `tick`, `valid`, `ovf` = 0.
- A reset asserted mid-operation takes effect at the next edge regardless of state.
- `busy` rises the cycle after IDLE sees `adjust`=1. It falls the cycle after `valid` or after an accepted abort.
- From `done` sampled high, the first tick comes `2+period` cycles later: SHIFT, LOAD, then `period` RUN cycles.
- Tick spacing is exactly `period` cycles. The burst is `n+1` ticks, the last one carrying `valid`.
- `period`=1 gives ticks on consecutive cycles.
- `burst_idx` can never exceed `n` if `n` is stable. If `n` is lowered below `burst_idx` mid-burst, the burst continues until `burst_idx` wraps to `n`.

## Test plan
- Nominal burst, defaults: pulse `adjust` 3 cycles, release, assert `done` after 12 MEAS cycles, `shamt`=2, `n`=2.
  - Required: `meas`=12, `period`=3, 3 ticks 3 cycles apart.
  - First tick 5 cycles after `done`; `valid` with the 3rd tick; `busy`=0 the next cycle.
- Minimum period: 2 MEAS cycles, `shamt`=3, `n`=3.
  - Required: `period` forced to 1; ticks on 4 consecutive RUN cycles; `valid` on the 4th.
- Immediate `done`: `done`=1 in the first MEAS cycle.
  - Required: `meas`=0, `period`=1, `ovf`=0.
- Overflow, `CNT_W`=4: `done` withheld for 20 MEAS cycles, `shamt`=0, `n`=0.
  - Required: `meas` saturates at 15, `ovf`=1, `period`=15, a single tick with `valid`.
  - `ovf` clears on the next ADJ→MEAS transition.
- Abort mid-burst: `n`=4, `period`=3, `abort`=1 one cycle after the first tick.
  - Required: IDLE next cycle, `busy`=0, no further `tick`/`valid`, `period` still 3.
- Reset mid-RUN: `rst` high 2 cycles during RUN.
  - Required: all outputs 0 the following cycle.
  - A subsequent `adjust` restarts normally from IDLE.
